// File: rtl/remote_cmd_sched_pkg.sv
// Shared types and defaults for the remote command scheduler and its arbiter.
package remote_cmd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_CMPLT     = 3'd4
  } state_e;

  localparam logic [7:0] ACK                = 8'hA5;
  localparam int         DEF_TIMEOUT_CYCLES = 50000;
  localparam int         DEF_MAX_RETRY      = 2;
  localparam int         NUM_REQ            = 2;

endpackage

// File: rtl/cmd_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority moves on update.
module cmd_rr_arb
  import remote_cmd_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] gnt
);

  logic last_q;
  logic last_d;

  // last_q resets to 1 so requester 0 takes the first tie
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    last_d = last_q;
    if (update && (|gnt)) last_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/remote_cmd_sched.sv
// Serialises two requesters onto one remote link, with response timeout and bounded re-send.
module remote_cmd_sched
  import remote_cmd_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [7:0]  cmd0,
  input  logic [7:0]  cmd1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [7:0]  resp_out,
  output logic        send_cmd,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  resp_q, resp_d;
  logic        timed_out_q, timed_out_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] cnt_q, cnt_d;

  logic [1:0]  arb_gnt;
  logic        arb_update;

  assign arb_update = (state_q == ST_IDLE) && (|req);

  cmd_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      timed_out_q <= 1'b0;
      retry_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      resp_q      <= resp_d;
      timed_out_q <= timed_out_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    resp_d      = resp_q;
    timed_out_d = timed_out_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = arb_gnt;
          cmd_d   = arb_gnt[1] ? cmd1 : cmd0;
          data_d  = arb_gnt[1] ? data1 : data0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (cmd_sent) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        cnt_d = cnt_q + 16'd1;
        // A response on the timeout cycle still wins
        if (resp_rdy) begin
          resp_d      = resp;
          timed_out_d = 1'b0;
          state_d     = ST_CMPLT;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_ISSUE;
          end else begin
            resp_d      = 8'h00;
            timed_out_d = 1'b1;
            state_d     = ST_CMPLT;
          end
        end
      end
      ST_CMPLT: begin
        gnt_d   = '0;
        retry_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    send_cmd     = (state_q == ST_ISSUE);
    clr_resp_rdy = (state_q == ST_ISSUE) || ((state_q == ST_WAIT_RESP) && resp_rdy);
    done         = (state_q == ST_CMPLT) ? gnt_q : 2'b00;
    err          = done & {2{timed_out_q || (resp_q != ACK)}};
  end

  assign gnt      = gnt_q;
  assign cmd      = cmd_q;
  assign data     = data_q;
  assign resp_out = resp_q;

endmodule

// File: tb/tb_remote_cmd_sched.sv
// Directed bench for remote_cmd_sched with a queue-based scoreboard for sends and completions.
module tb_remote_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  cmd0, cmd1;
  logic [15:0] data0, data1;
  logic [1:0]  gnt, done, err;
  logic [7:0]  resp_out;
  logic        send_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        clr_resp_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sends  = 0;

  logic [25:0] send_q[$];
  logic [11:0] done_q[$];

  remote_cmd_sched #(.TIMEOUT_CYCLES(20), .MAX_RETRY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .cmd0         (cmd0),
    .cmd1         (cmd1),
    .data0        (data0),
    .data1        (data1),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .resp_out     (resp_out),
    .send_cmd     (send_cmd),
    .cmd          (cmd),
    .data         (data),
    .cmd_sent     (cmd_sent),
    .resp_rdy     (resp_rdy),
    .resp         (resp),
    .clr_resp_rdy (clr_resp_rdy)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a send or a completion
  always @(negedge clk) begin
    logic [25:0] es;
    logic [11:0] ed;
    if (!rst && send_cmd) begin
      n_sends++;
      if (send_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_send: gnt=%b cmd=%h data=%h", gnt, cmd, data);
      end else begin
        es = send_q.pop_front();
        check("send{gnt,cmd,data}", {6'd0, gnt, cmd, data}, {6'd0, es});
      end
    end
    if (!rst && (done != 2'b00)) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=%b err=%b resp_out=%h", done, err, resp_out);
      end else begin
        ed = done_q.pop_front();
        check("done{done,err,resp_out}", {20'd0, done, err, resp_out}, {20'd0, ed});
      end
    end
  end

  task automatic wait_send();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (send_cmd) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("send_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic pulse_sent();
    @(negedge clk);
    cmd_sent = 1'b1;
    @(negedge clk);
    cmd_sent = 1'b0;
  endtask

  task automatic respond(input int delay, input logic [7:0] r);
    repeat (delay) @(negedge clk);
    resp     = r;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
  endtask

  task automatic wait_drain();
    bit empty = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (send_q.size() == 0 && done_q.size() == 0) begin
        empty = 1;
        break;
      end
    end
    if (!empty) check("drain_wait_expired", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int sends_before;
    rst = 1'b1; req = 2'b00; cmd0 = '0; cmd1 = '0; data0 = '0; data1 = '0;
    cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt_done_err", {28'd0, gnt, done}, 32'd0);
    check("rst_err", {30'd0, err}, 32'd0);
    check("rst_pulses", {30'd0, send_cmd, clr_resp_rdy}, 32'd0);
    check("rst_cmd_data", {8'd0, cmd, data}, 32'd0);
    check("rst_resp_out", {24'd0, resp_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Contention: grant order 0,1,0,1
    cmd0 = 8'h10; data0 = 16'h1000; cmd1 = 8'h21; data1 = 16'h2001;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        send_q.push_back({2'b01, 8'h10, 16'h1000});
        done_q.push_back({2'b01, 2'b00, 8'hA5});
      end else begin
        send_q.push_back({2'b10, 8'h21, 16'h2001});
        done_q.push_back({2'b10, 2'b00, 8'hA5});
      end
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_send();
      if (k == 3) req = 2'b00;
      pulse_sent();
      respond(0, 8'hA5);
    end
    wait_drain();

    // Single request
    cmd0 = 8'h05; data0 = 16'h1234;
    send_q.push_back({2'b01, 8'h05, 16'h1234});
    done_q.push_back({2'b01, 2'b00, 8'hA5});
    req = 2'b01;
    wait_send();
    req = 2'b00;
    pulse_sent();
    respond(2, 8'hA5);
    wait_drain();

    // NACK, no retry
    cmd0 = 8'h33; data0 = 16'hBEEF;
    send_q.push_back({2'b01, 8'h33, 16'hBEEF});
    done_q.push_back({2'b01, 2'b01, 8'hFF});
    req = 2'b01;
    wait_send();
    req = 2'b00;
    pulse_sent();
    respond(1, 8'hFF);
    wait_drain();

    // Timeout: three sends then err with resp_out 00
    cmd0 = 8'h44; data0 = 16'h0044;
    sends_before = n_sends;
    for (int k = 0; k < 3; k++) send_q.push_back({2'b01, 8'h44, 16'h0044});
    done_q.push_back({2'b01, 2'b01, 8'h00});
    req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      wait_send();
      req = 2'b00;
      pulse_sent();
    end
    wait_drain();
    repeat (25) @(negedge clk);
    check("timeout_send_count", n_sends - sends_before, 32'd3);

    // Response on the counter's last cycle is accepted, no re-send
    cmd1 = 8'h55; data1 = 16'h5555;
    sends_before = n_sends;
    send_q.push_back({2'b10, 8'h55, 16'h5555});
    done_q.push_back({2'b10, 2'b00, 8'hA5});
    req = 2'b10;
    wait_send();
    req = 2'b00;
    pulse_sent();
    respond(19, 8'hA5);
    wait_drain();
    repeat (25) @(negedge clk);
    check("boundary_send_count", n_sends - sends_before, 32'd1);

    // Reset during WAIT_RESP aborts with no done
    cmd0 = 8'h66; data0 = 16'h6666;
    send_q.push_back({2'b01, 8'h66, 16'h6666});
    req = 2'b01;
    wait_send();
    req = 2'b00;
    pulse_sent();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_gnt_done", {28'd0, gnt, done}, 32'd0);
    check("midrst_pulses", {30'd0, send_cmd, clr_resp_rdy}, 32'd0);
    check("midrst_cmd_data", {8'd0, cmd, data}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("final_send_q_empty", send_q.size(), 32'd0);
    check("final_done_q_empty", done_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
